// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle control FSM for instruction fetch and every PC update.
// Drives the registered PC-source select, the PC/IR/EPC enables and the hand-off to main control.
module pc_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       div_zero,
    input  logic       instr_done,
    output logic [2:0] pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       epc_write,
    output logic       exec_start
);
    // state        | meaning
    // S_RST        | post-reset idle, all outputs low
    // S_FETCH      | instruction memory read, pc_src = PC+4
    // S_FETCH_WAIT | memory read continues
    // S_FETCH_WR   | load IR and PC+4
    // S_DECODE     | pick path from opcode/funct
    // S_BR_CMP     | branch target selected, ALU compare resolves
    // S_J_SEL      | jump target selected
    // S_JR_SEL     | rs selected
    // S_RTE_SEL    | EPC selected
    // S_EXEC       | main control owns the datapath until done/exception
    // S_EXC_SEL    | exception vector selected, EPC captured
    // S_PC_WR      | load PC from the held selection
    localparam logic [3:0] S_RST        = 4'd0;
    localparam logic [3:0] S_FETCH      = 4'd1;
    localparam logic [3:0] S_FETCH_WAIT = 4'd2;
    localparam logic [3:0] S_FETCH_WR   = 4'd3;
    localparam logic [3:0] S_DECODE     = 4'd4;
    localparam logic [3:0] S_BR_CMP     = 4'd5;
    localparam logic [3:0] S_J_SEL      = 4'd6;
    localparam logic [3:0] S_JR_SEL     = 4'd7;
    localparam logic [3:0] S_RTE_SEL    = 4'd8;
    localparam logic [3:0] S_EXEC       = 4'd9;
    localparam logic [3:0] S_EXC_SEL    = 4'd10;
    localparam logic [3:0] S_PC_WR      = 4'd11;

    localparam logic [2:0] SRC_PC4 = 3'd0;
    localparam logic [2:0] SRC_BR  = 3'd1;
    localparam logic [2:0] SRC_J   = 3'd2;
    localparam logic [2:0] SRC_JR  = 3'd3;
    localparam logic [2:0] SRC_EPC = 3'd4;
    localparam logic [2:0] SRC_INV = 3'd5;
    localparam logic [2:0] SRC_OVF = 3'd6;
    localparam logic [2:0] SRC_DIV = 3'd7;

    logic [3:0] state_q, state_d;
    logic [2:0] pc_src_q, pc_src_d;
    logic       is_branch, is_jump, is_jr, is_rte, is_supported, br_taken, dec_exec;

    always_comb begin
        is_branch    = (opcode == 6'h04) || (opcode == 6'h05);
        is_jump      = (opcode == 6'h02) || (opcode == 6'h03);
        is_jr        = (opcode == 6'h00) && (funct == 6'h08);
        is_rte       = (opcode == 6'h00) && (funct == 6'h13);
        is_supported = (opcode == 6'h00) || (opcode == 6'h01) || (opcode == 6'h08) ||
                       (opcode == 6'h0F) || ((opcode >= 6'h20) && (opcode <= 6'h2B));
        br_taken     = ((opcode == 6'h04) && zero) || ((opcode == 6'h05) && !zero);
        dec_exec     = is_supported && !is_branch && !is_jump && !is_jr && !is_rte;
    end

    always_comb begin
        state_d  = state_q;
        pc_src_d = pc_src_q;
        case (state_q)
            S_RST: begin
                state_d  = S_FETCH;
                pc_src_d = SRC_PC4;
            end
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = S_FETCH_WR;
            S_FETCH_WR:   state_d = S_DECODE;
            // pc_src is loaded on the way into each select state so it is stable there
            S_DECODE: begin
                if (is_branch) begin
                    state_d  = S_BR_CMP;
                    pc_src_d = SRC_BR;
                end else if (is_jump) begin
                    state_d  = S_J_SEL;
                    pc_src_d = SRC_J;
                end else if (is_jr) begin
                    state_d  = S_JR_SEL;
                    pc_src_d = SRC_JR;
                end else if (is_rte) begin
                    state_d  = S_RTE_SEL;
                    pc_src_d = SRC_EPC;
                end else if (dec_exec) begin
                    state_d  = S_EXEC;
                end else begin
                    state_d  = S_EXC_SEL;
                    pc_src_d = SRC_INV;
                end
            end
            S_BR_CMP: begin
                if (br_taken) begin
                    state_d = S_PC_WR;
                end else begin
                    state_d  = S_FETCH;
                    pc_src_d = SRC_PC4;
                end
            end
            S_J_SEL, S_JR_SEL, S_RTE_SEL, S_EXC_SEL: state_d = S_PC_WR;
            S_EXEC: begin
                if (overflow) begin
                    state_d  = S_EXC_SEL;
                    pc_src_d = SRC_OVF;
                end else if (div_zero) begin
                    state_d  = S_EXC_SEL;
                    pc_src_d = SRC_DIV;
                end else if (instr_done) begin
                    state_d  = S_FETCH;
                    pc_src_d = SRC_PC4;
                end
            end
            S_PC_WR: begin
                state_d  = S_FETCH;
                pc_src_d = SRC_PC4;
            end
            default: begin
                state_d  = S_RST;
                pc_src_d = SRC_PC4;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RST;
            pc_src_q <= SRC_PC4;
        end else begin
            state_q  <= state_d;
            pc_src_q <= pc_src_d;
        end
    end

    // exec_start must land in the DECODE cycle, so it reads the IR fields (already registered)
    assign exec_start = (state_q == S_DECODE) && dec_exec;
    assign pc_src     = pc_src_q;
    assign pc_write   = (state_q == S_FETCH_WR) || (state_q == S_PC_WR);
    assign ir_write   = (state_q == S_FETCH_WR);
    assign mem_read   = (state_q == S_FETCH) || (state_q == S_FETCH_WAIT);
    assign epc_write  = (state_q == S_EXC_SEL);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle output vectors checked against hand-written tables.
// Output vector layout: {pc_src[2:0], pc_write, ir_write, mem_read, epc_write, exec_start}.
module tb_pc_sequencer;
    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       div_zero;
    logic       instr_done;
    logic [2:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       epc_write;
    logic       exec_start;
    logic [7:0] outs;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .overflow   (overflow),
        .div_zero   (div_zero),
        .instr_done (instr_done),
        .pc_src     (pc_src),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .epc_write  (epc_write),
        .exec_start (exec_start)
    );

    assign outs = {pc_src, pc_write, ir_write, mem_read, epc_write, exec_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (outs !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, outs, 8'h00);
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if (outs !== 8'h04) begin
            errors++;
            $display("FAIL reset_release_fetch: got %h expected %h", outs, 8'h04);
        end
    endtask

    task automatic test_beq_taken();
        logic [7:0] exp [7] = '{8'h04, 8'h04, 8'h18, 8'h00, 8'h20, 8'h30, 8'h04};
        opcode = 6'h04; funct = 6'h00; zero = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL beq_taken cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
            if (i < 6) step();
        end
    endtask

    task automatic test_beq_not_taken();
        logic [7:0] exp [6] = '{8'h04, 8'h04, 8'h18, 8'h00, 8'h20, 8'h04};
        opcode = 6'h04; funct = 6'h00; zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL beq_not_taken cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
            if (i < 5) step();
        end
    endtask

    task automatic test_bne();
        logic [7:0] exp_nt [6] = '{8'h04, 8'h04, 8'h18, 8'h00, 8'h20, 8'h04};
        logic [7:0] exp_t  [7] = '{8'h04, 8'h04, 8'h18, 8'h00, 8'h20, 8'h30, 8'h04};
        opcode = 6'h05; funct = 6'h00; zero = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (outs !== exp_nt[i]) begin
                errors++;
                $display("FAIL bne_not_taken cycle %0d: got %h expected %h", i, outs, exp_nt[i]);
            end
            if (i < 5) step();
        end
        zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (outs !== exp_t[i]) begin
                errors++;
                $display("FAIL bne_taken cycle %0d: got %h expected %h", i, outs, exp_t[i]);
            end
            if (i < 6) step();
        end
    endtask

    task automatic test_jumps();
        logic [5:0] ops [4] = '{6'h02, 6'h03, 6'h00, 6'h00};
        logic [5:0] fns [4] = '{6'h00, 6'h00, 6'h08, 6'h13};
        logic [7:0] exp [4][7] = '{
            '{8'h04, 8'h04, 8'h18, 8'h00, 8'h40, 8'h50, 8'h04},
            '{8'h04, 8'h04, 8'h18, 8'h00, 8'h40, 8'h50, 8'h04},
            '{8'h04, 8'h04, 8'h18, 8'h00, 8'h60, 8'h70, 8'h04},
            '{8'h04, 8'h04, 8'h18, 8'h00, 8'h80, 8'h90, 8'h04}};
        zero = 1'b0;
        for (int c = 0; c < 4; c++) begin
            opcode = ops[c]; funct = fns[c];
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (outs !== exp[c][i]) begin
                    errors++;
                    $display("FAIL jump case %0d cycle %0d: got %h expected %h", c, i, outs, exp[c][i]);
                end
                if (i < 6) step();
            end
        end
    endtask

    task automatic test_invalid_opcode();
        logic [5:0] ops [3] = '{6'h3F, 6'h2C, 6'h10};
        logic [7:0] exp [7] = '{8'h04, 8'h04, 8'h18, 8'h00, 8'hA2, 8'hB0, 8'h04};
        funct = 6'h20;
        for (int c = 0; c < 3; c++) begin
            opcode = ops[c];
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (outs !== exp[i]) begin
                    errors++;
                    $display("FAIL invalid_op %h cycle %0d: got %h expected %h", ops[c], i, outs, exp[i]);
                end
                if (i < 6) step();
            end
        end
    endtask

    task automatic test_exec_exception();
        logic [7:0] exp [11] = '{8'h04, 8'h04, 8'h18, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'hC2, 8'hD0, 8'h04};
        logic [2:0] ev  [11] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                 3'b111, 3'b000, 3'b000, 3'b000};
        opcode = 6'h00; funct = 6'h20;
        for (int i = 0; i < 11; i++) begin
            {overflow, div_zero, instr_done} = ev[i];
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL exec_overflow cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
            if (i < 10) step();
        end
    endtask

    task automatic test_exec_done();
        logic [7:0] exp [9] = '{8'h04, 8'h04, 8'h18, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
        logic [2:0] ev  [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b001, 3'b000};
        opcode = 6'h00; funct = 6'h20;
        for (int i = 0; i < 9; i++) begin
            {overflow, div_zero, instr_done} = ev[i];
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL exec_done cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
            if (i < 8) step();
        end
    endtask

    task automatic test_exec_div_zero();
        logic [7:0] exp [8] = '{8'h04, 8'h04, 8'h18, 8'h01, 8'h00, 8'hE2, 8'hF0, 8'h04};
        logic [2:0] ev  [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 3'b000};
        opcode = 6'h23; funct = 6'h00;
        for (int i = 0; i < 8; i++) begin
            {overflow, div_zero, instr_done} = ev[i];
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL exec_div_zero cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
            if (i < 7) step();
        end
    endtask

    // instr_done held high the whole time: only the EXEC cycle may act on it
    task automatic test_exec_boundary();
        logic [5:0] ops [4] = '{6'h2B, 6'h20, 6'h0F, 6'h01};
        logic [7:0] exp [6] = '{8'h04, 8'h04, 8'h18, 8'h01, 8'h00, 8'h04};
        funct = 6'h00;
        instr_done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            opcode = ops[c];
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (outs !== exp[i]) begin
                    errors++;
                    $display("FAIL exec_op %h cycle %0d: got %h expected %h", ops[c], i, outs, exp[i]);
                end
                if (i < 5) step();
            end
        end
        instr_done = 1'b0;
    endtask

    task automatic test_reset_in_pc_wr();
        logic [7:0] exp [8] = '{8'h04, 8'h04, 8'h18, 8'h00, 8'h20, 8'h30, 8'h00, 8'h04};
        logic       rs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 6'h04; funct = 6'h00; zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reset = rs[i];
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL reset_in_pc_wr cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_reset_in_exc_sel();
        logic [7:0] exp [7] = '{8'h04, 8'h04, 8'h18, 8'h00, 8'hA2, 8'h00, 8'h04};
        logic       rs  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 6'h3F; funct = 6'h00;
        for (int i = 0; i < 7; i++) begin
            reset = rs[i];
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL reset_in_exc_sel cycle %0d: got %h expected %h", i, outs, exp[i]);
            end
            if (i < 6) step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        opcode     = 6'h00;
        funct      = 6'h00;
        zero       = 1'b0;
        overflow   = 1'b0;
        div_zero   = 1'b0;
        instr_done = 1'b0;
        test_reset();
        test_beq_taken();
        test_beq_not_taken();
        test_bne();
        test_jumps();
        test_invalid_opcode();
        test_exec_exception();
        test_exec_done();
        test_exec_div_zero();
        test_exec_boundary();
        test_reset_in_pc_wr();
        test_reset_in_exc_sel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
